jts16_scrfetch: RTL

- Per-line and per-column scroll fetch scheduler for the S16B tilemap path.
- Sits between the scroll MMR outputs, the text-RAM read port and the tilemap renderers.
- When row/column scroll is enabled, reads the scroll tables from text RAM on line and 16-pixel-column events and replaces the MMR values with the fetched ones. When disabled, passes the MMR values through.
- Owns a single shared RAM read port and schedules row fetches ahead of column fetches.

---
 rtl/jts16_scrfetch.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/jts16_scrfetch.sv
// jts16_scrfetch
//   Row / column scroll fetch scheduler for the S16B tilemap path.
//   Reads the row-scroll table on each line start and the column-scroll table on
//   each 16-pixel column boundary through one shared text-RAM read port. The
//   fetched values replace the MMR scroll values. A layer whose enable is low
//   passes the MMR value through with one cycle of latency.
// Ports:
//   clk, rst_n               clock, synchronous active-low reset
//   hs, vrender              line-start strobe (rising edge) and line index
//   col_stb, col_idx         column boundary pulse and column index
//   rowscr*_en, colscr*_en   per-layer row / column scroll enables
//   scr*_hpos_in/vpos_in     MMR scroll values
//   ram_addr/cs/ok/data      text-RAM read port (request held until ram_ok)
//   scr*_hpos/vpos           effective scroll values
//   busy, col_ovf            FSM not idle; sticky lost-column-strobe flag
module jts16_scrfetch #(
  parameter logic [10:0] ROW_BASE = 11'h7A0,
  parameter logic [10:0] COL_BASE = 11'h7C0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hs,
  input  logic [8:0]  vrender,
  input  logic        col_stb,
  input  logic [4:0]  col_idx,
  input  logic        rowscr1_en,
  input  logic        rowscr2_en,
  input  logic        colscr1_en,
  input  logic        colscr2_en,
  input  logic [15:0] scr1_hpos_in,
  input  logic [15:0] scr2_hpos_in,
  input  logic [15:0] scr1_vpos_in,
  input  logic [15:0] scr2_vpos_in,
  output logic [10:0] ram_addr,
  output logic        ram_cs,
  input  logic        ram_ok,
  input  logic [15:0] ram_data,
  output logic [15:0] scr1_hpos,
  output logic [15:0] scr2_hpos,
  output logic [15:0] scr1_vpos,
  output logic [15:0] scr2_vpos,
  output logic        busy,
  output logic        col_ovf
);

  typedef enum logic [2:0] {IDLE, ROW1, ROW2, COL1, COL2, GAP} state_t;
  // What GAP continues into: the second half of a sequence, or a new pick.
  typedef enum logic [1:0] {CONT_NONE, CONT_ROW2, CONT_COL2} cont_t;

  state_t      state;
  cont_t       cont;
  logic        hs_d;
  logic        row_pend;
  logic        col_pend;
  logic        seq_col;     // current sequence is a column fetch
  logic [4:0]  pend_idx;
  logic [4:0]  cur_col;
  logic [4:0]  row_idx;
  logic [15:0] row_buf1;
  logic [15:0] row_buf2;

  logic       row_trig;
  logic       decide;
  logic       start_row;
  logic       start_col;
  logic [4:0] start_idx;
  logic       done;
  logic       unused_bits;

  function automatic logic [10:0] taddr(input logic [10:0] base,
                                        input logic [4:0] idx,
                                        input logic layer);
    return base + {5'd0, idx, layer};
  endfunction

  assign row_trig  = hs & ~hs_d;
  // A new sequence may only be chosen from IDLE or from a GAP that ends one.
  assign decide    = (state == IDLE) || (state == GAP && cont == CONT_NONE);
  assign start_row = decide & (row_pend | row_trig);
  assign start_col = decide & ~start_row & (col_pend | col_stb);
  assign start_idx = col_pend ? pend_idx : col_idx;
  assign done      = ram_cs & ram_ok;
  assign busy      = (state != IDLE);
  assign unused_bits = ^{vrender[8], vrender[2:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cont      <= CONT_NONE;
      hs_d      <= 1'b0;
      row_pend  <= 1'b0;
      col_pend  <= 1'b0;
      seq_col   <= 1'b0;
      pend_idx  <= 5'd0;
      cur_col   <= 5'd0;
      row_idx   <= 5'd0;
      row_buf1  <= 16'd0;
      row_buf2  <= 16'd0;
      ram_addr  <= 11'd0;
      ram_cs    <= 1'b0;
      scr1_hpos <= 16'd0;
      scr2_hpos <= 16'd0;
      scr1_vpos <= 16'd0;
      scr2_vpos <= 16'd0;
      col_ovf   <= 1'b0;
    end else begin
      hs_d <= hs;

      // Column request bookkeeping: a strobe not started now becomes pending;
      // a strobe landing on an unconsumed pending request is an overrun.
      col_pend <= (col_pend & ~start_col) | (col_stb & ~(start_col & ~col_pend));
      if (col_stb && !(start_col && !col_pend))
        pend_idx <= col_idx;
      if (col_stb && col_pend && !start_col)
        col_ovf <= 1'b1;

      if (start_row)
        row_pend <= 1'b0;
      else if (row_trig && state != IDLE && seq_col)
        row_pend <= 1'b1;

      case (state)
        IDLE, GAP: begin
          if (start_row) begin
            seq_col <= 1'b0;
            row_idx <= vrender[7:3];
            if (rowscr1_en) begin
              state    <= ROW1;
              ram_cs   <= 1'b1;
              ram_addr <= taddr(ROW_BASE, vrender[7:3], 1'b0);
            end else if (rowscr2_en) begin
              state    <= ROW2;
              ram_cs   <= 1'b1;
              ram_addr <= taddr(ROW_BASE, vrender[7:3], 1'b1);
            end else begin
              state <= IDLE;
            end
          end else if (start_col) begin
            seq_col <= 1'b1;
            cur_col <= start_idx;
            if (colscr1_en) begin
              state    <= COL1;
              ram_cs   <= 1'b1;
              ram_addr <= taddr(COL_BASE, start_idx, 1'b0);
            end else if (colscr2_en) begin
              state    <= COL2;
              ram_cs   <= 1'b1;
              ram_addr <= taddr(COL_BASE, start_idx, 1'b1);
            end else begin
              state <= IDLE;
            end
          end else if (state == GAP && cont == CONT_ROW2) begin
            state    <= ROW2;
            ram_cs   <= 1'b1;
            ram_addr <= taddr(ROW_BASE, row_idx, 1'b1);
          end else if (state == GAP && cont == CONT_COL2) begin
            state    <= COL2;
            ram_cs   <= 1'b1;
            ram_addr <= taddr(COL_BASE, cur_col, 1'b1);
          end else begin
            state <= IDLE;
          end
        end
        ROW1: if (done) begin
          row_buf1 <= ram_data;
          ram_cs   <= 1'b0;
          state    <= GAP;
          if (rowscr2_en) begin
            cont <= CONT_ROW2;
          end else begin
            // Last row fetch: commit both layers together.
            cont      <= CONT_NONE;
            scr1_hpos <= ram_data;
            scr2_hpos <= row_buf2;
          end
        end
        ROW2: if (done) begin
          row_buf2  <= ram_data;
          ram_cs    <= 1'b0;
          state     <= GAP;
          cont      <= CONT_NONE;
          scr1_hpos <= row_buf1;
          scr2_hpos <= ram_data;
        end
        COL1: if (done) begin
          scr1_vpos <= ram_data;
          ram_cs    <= 1'b0;
          state     <= GAP;
          cont      <= colscr2_en ? CONT_COL2 : CONT_NONE;
        end
        COL2: if (done) begin
          scr2_vpos <= ram_data;
          ram_cs    <= 1'b0;
          state     <= GAP;
          cont      <= CONT_NONE;
        end
        default: begin
          state  <= IDLE;
          ram_cs <= 1'b0;
        end
      endcase

      // Disabled layers track the MMR value every cycle, overriding any commit.
      if (!rowscr1_en) scr1_hpos <= scr1_hpos_in;
      if (!rowscr2_en) scr2_hpos <= scr2_hpos_in;
      if (!colscr1_en) scr1_vpos <= scr1_vpos_in;
      if (!colscr2_en) scr2_vpos <= scr2_vpos_in;
    end
  end

endmodule
